alu_share_arbiter: RTL

- Shares one combinational ALU (add/sub/logic plus the CMPEQ/CMPLT/CMPLE compare path) between N_REQ requesters, e.g. the main datapath and a branch/compare unit.
- Each requester uses a valid/ready request channel. The block grants requesters round-robin, drives the ALU from registered operands, captures the result and zero flag, and returns them on a single tagged response channel.
- Sits between requester ports and the ALU instance; one operation in flight at a time.

---
 rtl/alu_share_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Time-shares one external combinational ALU between N_REQ
//            requesters. Requests are granted round-robin, operands are
//            registered and driven to the ALU for one cycle, and the captured
//            result/zero flag is returned on a single tagged response channel.
//            One operation is in flight at a time.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_valid/req_ready   - per-requester handshake (one-hot ready)
//            req_a/req_b/req_ctrl  - packed per-requester payload
//            alu_a/alu_b/alu_ctrl  - registered operands to the ALU
//            alu_result/alu_zero   - combinational ALU outputs
//            rsp_valid/rsp_ready   - response handshake
//            rsp_id/rsp_result/rsp_zero - response payload
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int N_REQ  = 2,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int ID_W   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*WIDTH-1:0]    req_a,
    input  logic [N_REQ*WIDTH-1:0]    req_b,
    input  logic [N_REQ*CTRL_W-1:0]   req_ctrl,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [CTRL_W-1:0]         alu_ctrl,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WIDTH-1:0]          rsp_result,
    output logic                      rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;

    // Round-robin search done as two priority passes: the first valid index
    // at or above the pointer wins; otherwise the lowest valid index wraps in.
    logic               w_found_hi;
    logic               w_found;
    logic [ID_W-1:0]    w_win_hi;
    logic [ID_W-1:0]    w_win_lo;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_rr_nxt;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [CTRL_W-1:0]  w_sel_ctrl;
    logic               w_accept;

    always_comb begin
        w_found_hi = 1'b0;
        w_found    = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !w_found_hi && (ID_W'(i) >= r_rr_ptr)) begin
                w_found_hi = 1'b1;
                w_win_hi   = ID_W'(i);
            end
            if (req_valid[i] && !w_found) begin
                w_found  = 1'b1;
                w_win_lo = ID_W'(i);
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
        w_rr_nxt = (w_winner == c_last_id) ? '0 : w_winner + ID_W'(1);
    end

    // Payload mux indexed by constant slices only.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a    = req_a[i*WIDTH +: WIDTH];
                w_sel_b    = req_b[i*WIDTH +: WIDTH];
                w_sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (w_winner == ID_W'(i));
                    end
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_ctrl   <= w_sel_ctrl;
                r_id     <= w_winner;
                r_rr_ptr <= w_rr_nxt;
            end
            // The ALU is combinational on the latched operands, so its output
            // is only meaningful (and only sampled) during EXEC.
            if (r_state == EXEC) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_ctrl   = r_ctrl;
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;

endmodule
`default_nettype wire
